// File: rtl/reaction_timing_engine.sv
// Multi-player reaction timer: BCD elapsed-time counter, per-player score latches,
// winner/best-time tracking, overflow saturation and status LEDs.
module reaction_timing_engine #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000,
   parameter int DIGITS  = 3,
   parameter int PLAYERS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [PLAYERS-1:0]          key_n,
   output logic [4*DIGITS-1:0]         time_bcd,
   output logic [PLAYERS*4*DIGITS-1:0] score_bcd,
   output logic [PLAYERS-1:0]          score_vld,
   output logic [4*DIGITS-1:0]         best_bcd,
   output logic [1:0]                  winner,
   output logic                        overflow,
   output logic [9:0]                  ledr,
   output logic [3:0]                  out_state
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int TW  = 4 * DIGITS;
   localparam logic [TW-1:0] ALL9      = {DIGITS{4'h9}};
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 en_q, en_d;
   logic [PLAYERS-1:0]   key_q, key_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [TW-1:0]        time_q, time_d;
   logic [TW-1:0]        score_q [PLAYERS];
   logic [TW-1:0]        score_d [PLAYERS];
   logic [PLAYERS-1:0]   vld_q, vld_d;
   logic [TW-1:0]        best_q, best_d;
   logic [1:0]           winner_q, winner_d;
   logic                 ovf_q, ovf_d;
   logic [9:0]           ledr_q, ledr_d;

   logic                 start, all_vld, run_act, tick, sat, done_entry;
   logic [PLAYERS-1:0]   stop;
   logic [TW-1:0]        inc, min_v;
   logic [3:0]           dig;
   logic                 carry;

   // Control decode; a run with every score already latched does no more counting.
   always_comb begin
      start   = en && !en_q && (state_q != S_RUN);
      all_vld = &vld_q;
      run_act = (state_q == S_RUN) && en && !all_vld;
      tick    = run_act && (presc_q == PRESC_MAX);
      sat     = tick && (time_q == ALL9);
      stop    = run_act ? (~key_n & key_q & ~vld_q) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (!en)                  state_d = S_IDLE;
            else if (all_vld || sat)  state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      en_d     = en;
      key_d    = key_n;
      presc_d  = presc_q;
      time_d   = time_q;
      score_d  = score_q;
      vld_d    = vld_q;
      best_d   = best_q;
      winner_d = winner_q;
      ovf_d    = ovf_q;
      done_entry = (state_q == S_RUN) && (state_d == S_DONE);

      inc   = time_q;
      carry = 1'b1;
      dig   = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         dig = time_q[4*d +: 4];
         if (carry) begin
            if (dig == 4'd9) dig = 4'd0;
            else begin
               dig   = dig + 4'd1;
               carry = 1'b0;
            end
         end
         inc[4*d +: 4] = dig;
      end

      if (start) begin
         presc_d = '0;
         time_d  = '0;
         vld_d   = '0;
         ovf_d   = 1'b0;
         for (int unsigned p = 0; p < PLAYERS; p++) score_d[p] = '0;
      end else if (run_act) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (stop[p]) begin
               score_d[p] = time_q;
               vld_d[p]   = 1'b1;
            end
         end
         if (sat) begin
            ovf_d = 1'b1;
            for (int unsigned p = 0; p < PLAYERS; p++)
               if (!vld_d[p]) score_d[p] = ALL9;
            vld_d = '1;
         end else if (tick) begin
            time_d = inc;
         end
      end

      // Scores as they will be latched this edge; BCD orders like binary.
      min_v = score_d[0];
      if (done_entry) begin
         winner_d = '0;
         for (int unsigned p = 1; p < PLAYERS; p++) begin
            if (score_d[p] < min_v) begin
               min_v    = score_d[p];
               winner_d = 2'(p);
            end
         end
         if (min_v < best_q) best_d = min_v;
      end

      case (state_d)
         S_RUN:   ledr_d = 10'h3FF;
         S_DONE:  ledr_d = 10'd1 << winner_d;
         default: ledr_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b1;
         key_q    <= '1;
         presc_q  <= '0;
         time_q   <= '0;
         vld_q    <= '0;
         best_q   <= ALL9;
         winner_q <= '0;
         ovf_q    <= 1'b0;
         ledr_q   <= '0;
         for (int unsigned p = 0; p < PLAYERS; p++) score_q[p] <= '0;
      end else begin
         en_q     <= en_d;
         key_q    <= key_d;
         presc_q  <= presc_d;
         time_q   <= time_d;
         vld_q    <= vld_d;
         best_q   <= best_d;
         winner_q <= winner_d;
         ovf_q    <= ovf_d;
         ledr_q   <= ledr_d;
         for (int unsigned p = 0; p < PLAYERS; p++) score_q[p] <= score_d[p];
      end
   end

   always_comb begin
      out_state = (state_q == S_DONE) ? 4'd3 : 4'd2;
      time_bcd  = time_q;
      score_vld = vld_q;
      best_bcd  = best_q;
      winner    = winner_q;
      overflow  = ovf_q;
      ledr      = ledr_q;
      score_bcd = '0;
      for (int unsigned p = 0; p < PLAYERS; p++) score_bcd[p*TW +: TW] = score_q[p];
   end

endmodule

// File: tb/tb_reaction_timing_engine.sv
// Bench for reaction_timing_engine (10 Hz clock, 1 Hz tick, 2 digits, 2 players):
// key schedules are turned into expected scores/winner/best with plain arithmetic.
module tb_reaction_timing_engine;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [1:0]  key_n;
   logic [7:0]  time_bcd;
   logic [15:0] score_bcd;
   logic [1:0]  score_vld;
   logic [7:0]  best_bcd;
   logic [1:0]  winner;
   logic        overflow;
   logic [9:0]  ledr;
   logic [3:0]  out_state;

   int vectors = 0;
   int errors  = 0;

   // Per player: pre-run level low flag, and two low windows [a0,a1) and [b0,b1) in run cycles.
   int pre_lo [2];
   int a0 [2], a1 [2], b0 [2], b1 [2];

   int best_m = 99;
   int win_m  = 0;
   bit ovf_m  = 1'b0;

   reaction_timing_engine #(
      .CLK_HZ (10),
      .TICK_HZ(1),
      .DIGITS (2),
      .PLAYERS(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .key_n    (key_n),
      .time_bcd (time_bcd),
      .score_bcd(score_bcd),
      .score_vld(score_vld),
      .best_bcd (best_bcd),
      .winner   (winner),
      .overflow (overflow),
      .ledr     (ledr),
      .out_state(out_state)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic bit key_lvl(input int p, input int c);
      if (c < 0) return (pre_lo[p] == 0);
      return !((c >= a0[p] && c < a1[p]) || (c >= b0[p] && c < b1[p]));
   endfunction

   task automatic set_sched(input int p, input int pre, input int wa0, input int wa1,
                            input int wb0, input int wb1);
      pre_lo[p] = pre; a0[p] = wa0; a1[p] = wa1; b0[p] = wb0; b1[p] = wb1;
   endtask

   // Returns just after the edge that enters RUN (cycle 0 follows).
   task automatic start_run();
      @(posedge clk); #1;
      en    = 1'b0;
      key_n = {key_lvl(1, -1), key_lvl(0, -1)};
      @(posedge clk); #1;
      en = 1'b1;
      @(posedge clk);
   endtask

   task automatic drive_run();
      int sc [2];
      int fc [2];
      bit got [2];
      int last, done_c, limit, mn, wexp, t_exp;
      bit ovf_e;
      for (int p = 0; p < 2; p++) begin
         got[p] = 1'b0; sc[p] = 99; fc[p] = 0;
         for (int c = 0; c < 1000; c++)
            if (!got[p] && key_lvl(p, c - 1) && !key_lvl(p, c)) begin
               got[p] = 1'b1; sc[p] = c / 10; fc[p] = c;
            end
      end
      last   = (fc[0] > fc[1]) ? fc[0] : fc[1];
      ovf_e  = !(got[0] && got[1] && last <= 998);
      done_c = ovf_e ? 1000 : last + 2;
      limit  = ovf_e ? 999 : last;
      mn = sc[0]; wexp = 0;
      if (sc[1] < mn) begin mn = sc[1]; wexp = 1; end
      t_exp = ovf_e ? 99 : (last + 1) / 10;

      start_run();
      for (int c = 0; c <= done_c + 1; c++) begin
         #1 key_n = {key_lvl(1, c), key_lvl(0, c)};
         @(negedge clk);
         if (c <= limit) begin
            vectors++;
            if (time_bcd !== bcd(c / 10)) begin
               errors++;
               $display("FAIL live_time cycle %0d: got %h want %h", c, time_bcd, bcd(c / 10));
            end
         end
         @(posedge clk);
      end
      @(negedge clk);
      if (mn < best_m) best_m = mn;
      win_m = wexp;
      ovf_m = ovf_e;

      vectors++; if (out_state !== 4'd3) begin errors++; $display("FAIL run_state: got %0d want 3", out_state); end
      vectors++; if (winner !== 2'(wexp)) begin errors++; $display("FAIL run_winner: got %0d want %0d", winner, wexp); end
      vectors++; if (ledr !== (10'd1 << wexp)) begin errors++; $display("FAIL run_ledr: got %h want %h", ledr, 10'd1 << wexp); end
      vectors++; if (best_bcd !== bcd(best_m)) begin errors++; $display("FAIL run_best: got %h want %h", best_bcd, bcd(best_m)); end
      vectors++; if (overflow !== ovf_e) begin errors++; $display("FAIL run_overflow: got %b want %b", overflow, ovf_e); end
      vectors++; if (score_vld !== 2'b11) begin errors++; $display("FAIL run_vld: got %b want 11", score_vld); end
      vectors++; if (score_bcd[7:0] !== bcd(sc[0])) begin errors++; $display("FAIL run_score0: got %h want %h", score_bcd[7:0], bcd(sc[0])); end
      vectors++; if (score_bcd[15:8] !== bcd(sc[1])) begin errors++; $display("FAIL run_score1: got %h want %h", score_bcd[15:8], bcd(sc[1])); end
      if (ovf_e || ((last + 1) % 10) != 9) begin
         vectors++;
         if (time_bcd !== bcd(t_exp)) begin errors++; $display("FAIL run_time_hold: got %h want %h", time_bcd, bcd(t_exp)); end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (time_bcd !== 8'h00) begin errors++; $display("FAIL rst_time: got %h want 00", time_bcd); end
      vectors++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_score: got %h want 0000", score_bcd); end
      vectors++; if (score_vld !== 2'b00) begin errors++; $display("FAIL rst_vld: got %b want 00", score_vld); end
      vectors++; if (best_bcd !== 8'h99) begin errors++; $display("FAIL rst_best: got %h want 99", best_bcd); end
      vectors++; if (winner !== 2'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_win_ovf: got %0d/%b want 0/0", winner, overflow); end
      vectors++; if (ledr !== 10'h000 || out_state !== 4'd2) begin errors++; $display("FAIL rst_ledr_state: got %h/%0d want 000/2", ledr, out_state); end
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      vectors++; if (ledr !== 10'h000) begin errors++; $display("FAIL rst_en_high_no_start: got ledr %h want 000", ledr); end
   endtask

   task automatic test_basic();
      set_sched(0, 0, 125, 400, -1, -1);
      set_sched(1, 0, 200, 400, -1, -1);
      drive_run();
      vectors++; if (score_bcd[7:0] !== 8'h12 || score_bcd[15:8] !== 8'h20) begin errors++; $display("FAIL basic_scores: got %h want 2012", score_bcd); end
      vectors++; if (best_bcd !== 8'h12 || ledr !== 10'h001) begin errors++; $display("FAIL basic_best_ledr: got %h/%h want 12/001", best_bcd, ledr); end
   endtask

   task automatic test_tie();
      set_sched(0, 0, 69, 90, -1, -1);
      set_sched(1, 0, 69, 90, -1, -1);
      drive_run();
      vectors++; if (score_bcd !== 16'h0606 || winner !== 2'd0) begin errors++; $display("FAIL tie_scores: got %h w%0d want 0606 w0", score_bcd, winner); end
   endtask

   task automatic test_overflow();
      set_sched(0, 0, -1, -1, -1, -1);
      set_sched(1, 0, -1, -1, -1, -1);
      drive_run();
      vectors++; if (time_bcd !== 8'h99 || overflow !== 1'b1 || score_bcd !== 16'h9999) begin
         errors++; $display("FAIL ovf_result: got t%h o%b s%h want t99 o1 s9999", time_bcd, overflow, score_bcd);
      end
   endtask

   task automatic test_false_start();
      set_sched(0, 0, 20, 25, 40, 2000);
      set_sched(1, 1, 0, 30, 50, 2000);
      drive_run();
      vectors++; if (score_bcd[15:8] !== 8'h05) begin errors++; $display("FAIL false_start: got %h want 05", score_bcd[15:8]); end
      vectors++; if (score_bcd[7:0] !== 8'h02) begin errors++; $display("FAIL repeat_press: got %h want 02", score_bcd[7:0]); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 3) == 0) begin
               pre_lo[p] = 1; a0[p] = 0; a1[p] = int'($urandom_range(1, 300));
            end else begin
               pre_lo[p] = 0; a0[p] = int'($urandom_range(0, 1100)); a1[p] = a0[p] + int'($urandom_range(1, 60));
            end
            b0[p] = a1[p] + int'($urandom_range(1, 40));
            b1[p] = b0[p] + int'($urandom_range(1, 60));
         end
         drive_run();
      end
   endtask

   task automatic test_abort();
      int w_exp, b_exp;
      bit o_exp;
      w_exp = win_m; b_exp = best_m; o_exp = ovf_m;
      set_sched(0, 0, 35, 40, -1, -1);
      set_sched(1, 0, -1, -1, -1, -1);
      start_run();
      for (int c = 0; c <= 60; c++) begin
         #1 key_n = {key_lvl(1, c), key_lvl(0, c)};
         if (c == 60) en = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      vectors++; if (ledr !== 10'h000 || out_state !== 4'd2) begin errors++; $display("FAIL abort_idle: got %h/%0d want 000/2", ledr, out_state); end
      vectors++; if (best_bcd !== bcd(b_exp) || winner !== 2'(w_exp) || overflow !== o_exp) begin
         errors++; $display("FAIL abort_keep: got b%h w%0d o%b want b%h w%0d o%b", best_bcd, winner, overflow, bcd(b_exp), w_exp, o_exp);
      end
      vectors++; if (score_vld !== 2'b01 || score_bcd !== 16'h0003) begin errors++; $display("FAIL abort_partial: got v%b s%h want v01 s0003", score_vld, score_bcd); end
   endtask

   task automatic test_rst_midrun();
      set_sched(0, 0, -1, -1, -1, -1);
      set_sched(1, 0, -1, -1, -1, -1);
      start_run();
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      best_m = 99; win_m = 0; ovf_m = 1'b0;
      vectors++; if (ledr !== 10'h000 || time_bcd !== 8'h00 || best_bcd !== 8'h99) begin
         errors++; $display("FAIL midrun_rst: got l%h t%h b%h want l000 t00 b99", ledr, time_bcd, best_bcd);
      end
      vectors++; if (score_bcd !== 16'h0 || score_vld !== 2'b00 || winner !== 2'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL midrun_rst_regs: got s%h v%b w%0d o%b want zeros", score_bcd, score_vld, winner, overflow);
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      vectors++; if (ledr !== 10'h000 || time_bcd !== 8'h00) begin errors++; $display("FAIL midrun_no_restart: got l%h t%h want 000/00", ledr, time_bcd); end
      start_run();
      @(negedge clk);
      vectors++; if (ledr !== 10'h3FF || out_state !== 4'd2) begin errors++; $display("FAIL restart_run: got %h/%0d want 3ff/2", ledr, out_state); end
      repeat (15) @(posedge clk);
      @(negedge clk);
      vectors++; if (time_bcd !== 8'h01) begin errors++; $display("FAIL restart_count: got %h want 01", time_bcd); end
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      key_n = 2'b11;
      test_reset();
      test_basic();
      test_tie();
      test_overflow();
      test_false_start();
      test_random();
      test_abort();
      test_rst_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/reaction_timing_engine.md
REACTION_TIMING_ENGINE -- requirements
Module: reaction_timing_engine

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, meaning count rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2.
REQ-003 SHALL have parameter DIGITS, default 3, meaning number of BCD digits in the elapsed-time counter (1..6).
REQ-004 SHALL have parameter PLAYERS, default 2, meaning number of independent stop keys and score channels (1..4).
REQ-005 SHALL use one clock with a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port en, input, 1 bit: arm/run request, level; a rising edge starts a run.
REQ-009 SHALL have port key_n, input, PLAYERS bits: active-low stop keys, already synchronised upstream.
REQ-010 SHALL have port time_bcd, output, 4*DIGITS bits: live elapsed count, digit 0 in LSBs.
REQ-011 SHALL have port score_bcd, output, PLAYERS*4*DIGITS bits: latched score per player, player p at slice p.
REQ-012 SHALL have port score_vld, output, PLAYERS bits: per-player score-latched flag.
REQ-013 SHALL have port best_bcd, output, 4*DIGITS bits: lowest score since reset.
REQ-014 SHALL have port winner, output, 2 bits: index of the fastest player in the last completed run.
REQ-015 SHALL have port overflow, output, 1 bit: the last run saturated.
REQ-016 SHALL have port ledr, output, 10 bits: status LEDs.
REQ-017 SHALL have port out_state, output, 4 bits: top-level state code.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE; en_q is en registered by one cycle; an edge means en=1 and en_q=0.
REQ-019 SHALL, in IDLE or DONE, on an en rising edge: clear time_bcd, prescaler, score_vld and overflow; load every score to 0; enter RUN on the next cycle.
REQ-020 SHALL, in RUN, pulse tick for one cycle when the prescaler equals DIV-1, then wrap the prescaler to 0; the first tick SHALL occur DIV cycles after RUN entry.
REQ-021 SHALL, on tick, increment time_bcd as a decimal counter: digit 9 wraps to 0 and carries into the next digit in the same cycle; no digit ever holds a value above 9.
REQ-022 SHALL detect a stop for player p when key_n[p]=0 and the previous-cycle key_n[p]=1 while in RUN and score_vld[p]=0; a key already low at RUN entry SHALL NOT count until it is released and pressed again.
REQ-023 SHALL, on a stop, latch the pre-increment time_bcd (the register value at that edge, even if tick is asserted in the same cycle) into score p and set score_vld[p].
REQ-024 SHALL ignore further presses by a player whose score_vld bit is already set, until the next run.
REQ-025 SHALL latch the same value for simultaneous stops by several players; the lowest index among them wins the tie.
REQ-026 SHALL, once all score_vld bits are 1, enter DONE on the following cycle and hold time_bcd.
REQ-027 SHALL, when time_bcd is all 9s and tick is asserted: keep time_bcd at all 9s (no wrap), set overflow, load all 9s into every non-valid score, set all score_vld bits, and enter DONE.
REQ-028 SHALL, on DONE entry, set winner to the index of the minimum score (lowest index on ties); best_bcd SHALL take that minimum if it is strictly lower than the current best_bcd.
REQ-029 SHALL, if en falls during RUN, abort to IDLE: winner, best_bcd and overflow unchanged; scores and score_vld keep their partial values.
REQ-030 SHALL drive ledr = 10'h3FF in RUN; in DONE, ledr[winner]=1 and all other bits 0; in IDLE, ledr = 0 (ledr is registered).
REQ-031 SHALL drive out_state = 2 in IDLE and RUN, and 3 in DONE (combinational from state).

Reset
REQ-032 SHALL, on rst=1 at a clk edge, set: state IDLE, prescaler 0, time_bcd 0, all scores 0, score_vld 0, best_bcd all 9s, winner 0, overflow 0, ledr 0, en_q 1 (so en held high through reset does not start a run); rst SHALL take priority over all other inputs, including mid-run.

Verification (CLK_HZ=10, TICK_HZ=1, DIGITS=2, PLAYERS=2 unless noted)
REQ-033 SHALL verify basic run: en rises; key_n[0] falls 125 cycles after RUN entry; key_n[1] falls at 200 -> score0=12, score1=20, winner=0, best=12, out_state=3, ledr=10'h001.
REQ-034 SHALL verify tie and the tick boundary: both keys fall on the same cycle as the 7th tick -> both scores=06 (pre-increment), winner=0.
REQ-035 SHALL verify overflow: no keys pressed -> time_bcd reaches 99 at the 990th cycle and holds 99; overflow=1, both scores=99, DONE.
REQ-036 SHALL verify false-start and repeat press: key_n[1] held low through the en rise, released at cycle 30 and pressed at 50 -> score1=05; a second press by player 0 is ignored.
REQ-037 SHALL verify abort and reset: en falls mid-run -> IDLE with best unchanged; rst asserted in RUN with en still high -> IDLE, best=99, no restart until en falls and rises again.
